// File: rtl/el2_pmp_csr_if.sv
// CSR request/response channel for the PMP register block.
// Ports: req valid/ready/we/addr/wdata, rsp valid/ready/rdata/err.
interface el2_pmp_csr_if;
    logic        csr_req_valid;
    logic        csr_req_ready;
    logic        csr_req_we;
    logic [11:0] csr_req_addr;
    logic [31:0] csr_req_wdata;
    logic        csr_rsp_valid;
    logic        csr_rsp_ready;
    logic [31:0] csr_rsp_rdata;
    logic        csr_rsp_err;

    modport master (
        output csr_req_valid, csr_req_we, csr_req_addr,
        output csr_req_wdata, csr_rsp_ready,
        input  csr_req_ready, csr_rsp_valid,
        input  csr_rsp_rdata, csr_rsp_err
    );

    modport slave (
        input  csr_req_valid, csr_req_we, csr_req_addr,
        input  csr_req_wdata, csr_rsp_ready,
        output csr_req_ready, csr_rsp_valid,
        output csr_rsp_rdata, csr_rsp_err
    );
endinterface

// File: rtl/el2_pmp_csr.sv
// PMP CSR file: pmpcfg/pmpaddr/mseccfg with lock rules, one-entry response.
// Ports: clk, rst (sync high), bus (slave), pmp_pmpcfg, pmp_pmpaddr, mseccfg.
module el2_pmp_csr #(
    parameter int PMP_ENTRIES     = 16,
    parameter int PMP_GRANULARITY = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    el2_pmp_csr_if.slave                 bus,
    output logic [PMP_ENTRIES-1:0][7:0]  pmp_pmpcfg,
    output logic [PMP_ENTRIES-1:0][31:0] pmp_pmpaddr,
    output logic [2:0]                   mseccfg
);
    localparam int G  = PMP_GRANULARITY;
    localparam int GN = (G >= 2) ? G - 1 : 0;
    localparam int GO = (G >= 1) ? G : 0;
    // Read-only address bit masks implied by the granule size.
    localparam logic [31:0] NAPOT_ONES = (32'h1 << GN) - 32'h1;
    localparam logic [31:0] LOW_ZERO   = (32'h1 << GO) - 32'h1;

    typedef enum logic {IDLE, RESP} state_t;

    state_t      state;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [31:0] rd_data;
    logic [3:0]  idx;
    logic        sel_cfg;
    logic        sel_addr;
    logic        sel_msec;
    logic        unmapped;
    logic        accept;
    logic        rlb;
    logic        mml;
    logic        any_lock;
    logic [PMP_ENTRIES-1:0] tor_lock;
    logic [2:0]  msec_next;
    logic [31:0] wd;

    assign bus.csr_req_ready = (state == IDLE) | bus.csr_rsp_ready;
    assign bus.csr_rsp_valid = (state == RESP);
    assign bus.csr_rsp_rdata = rdata_q;
    assign bus.csr_rsp_err   = err_q;

    assign accept = bus.csr_req_valid & bus.csr_req_ready;
    assign idx    = bus.csr_req_addr[3:0];
    assign wd     = bus.csr_req_wdata;

    assign sel_cfg  = (bus.csr_req_addr[11:4] == 8'h3A) &&
                      ({1'b0, idx} < 5'(PMP_ENTRIES / 4));
    assign sel_addr = (bus.csr_req_addr[11:4] == 8'h3B) &&
                      ({1'b0, idx} < 5'(PMP_ENTRIES));
    assign sel_msec = (bus.csr_req_addr == 12'h747);
    assign unmapped = ~(sel_cfg | sel_addr | sel_msec);

    assign mml = mseccfg[0];
    assign rlb = mseccfg[2];

    always_comb begin
        any_lock = 1'b0;
        for (int e = 0; e < PMP_ENTRIES; e++) begin
            any_lock = any_lock | pmp_pmpcfg[e][7];
        end
    end

    // A locked TOR entry also protects the base address held in the entry below.
    always_comb begin
        tor_lock = '0;
        for (int e = 0; e < PMP_ENTRIES - 1; e++) begin
            tor_lock[e] = pmp_pmpcfg[e+1][7] &
                          (pmp_pmpcfg[e+1][4:3] == 2'b01);
        end
    end

    // RLB can only be raised while no entry is locked.
    assign msec_next = {wd[2] & (rlb | ~any_lock),
                        mseccfg[1] | wd[1],
                        mseccfg[0] | wd[0]};

    function automatic logic [7:0] cfg_next(
        input logic [7:0] o,
        input logic [7:0] n,
        input logic       rlb_i,
        input logic       mml_i
    );
        logic       skip;
        logic       w_only;
        logic [1:0] a;
        w_only = n[1] & ~n[0];
        skip   = (o[7] & ~rlb_i) |
                 (~mml_i & w_only) |
                 (mml_i & ~rlb_i & n[7] & (n[2] | w_only));
        // NA4 is not selectable once the granule exceeds 4 bytes.
        a = ((G >= 1) && (n[4:3] == 2'b10)) ? o[4:3] : n[4:3];
        return skip ? o : {n[7], 2'b00, a, n[2:0]};
    endfunction

    function automatic logic [31:0] addr_rd(
        input logic [31:0] a,
        input logic [7:0]  c
    );
        logic [31:0] r;
        r = a;
        if (c[4:3] == 2'b11) begin
            r = a | NAPOT_ONES;
        end else if (!c[4]) begin
            r = a & ~LOW_ZERO;
        end
        return r;
    endfunction

    always_comb begin
        rd_data = '0;
        unique case (1'b1)
            sel_cfg: begin
                for (int e = 0; e < PMP_ENTRIES; e++) begin
                    if (idx == 4'(e / 4)) begin
                        rd_data[8*(e%4) +: 8] = pmp_pmpcfg[e];
                    end
                end
            end
            sel_addr: begin
                for (int e = 0; e < PMP_ENTRIES; e++) begin
                    if (idx == 4'(e)) begin
                        rd_data = addr_rd(pmp_pmpaddr[e], pmp_pmpcfg[e]);
                    end
                end
            end
            sel_msec: rd_data = {29'd0, mseccfg};
            default:  rd_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            pmp_pmpcfg  <= '0;
            pmp_pmpaddr <= '0;
            mseccfg     <= '0;
        end else if (accept) begin
            state   <= RESP;
            rdata_q <= rd_data;
            err_q   <= unmapped;
            if (bus.csr_req_we && sel_cfg) begin
                for (int e = 0; e < PMP_ENTRIES; e++) begin
                    if (idx == 4'(e / 4)) begin
                        pmp_pmpcfg[e] <= cfg_next(pmp_pmpcfg[e],
                                                  wd[8*(e%4) +: 8],
                                                  rlb, mml);
                    end
                end
            end
            if (bus.csr_req_we && sel_addr) begin
                for (int e = 0; e < PMP_ENTRIES; e++) begin
                    if (idx == 4'(e) &&
                        !((pmp_pmpcfg[e][7] | tor_lock[e]) & ~rlb)) begin
                        pmp_pmpaddr[e] <= wd;
                    end
                end
            end
            if (bus.csr_req_we && sel_msec) begin
                mseccfg <= msec_next;
            end
        end else if (bus.csr_rsp_ready) begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_el2_pmp_csr.sv
// Directed bench for el2_pmp_csr with immediate-assertion checks.
// Ports: drives the CSR channel, observes pmp outputs and responses.
module tb_el2_pmp_csr;
    logic clk;
    logic rst;
    logic [15:0][7:0]  pmp_pmpcfg;
    logic [15:0][31:0] pmp_pmpaddr;
    logic [2:0]        mseccfg;
    int n_chk;
    int n_fail;

    el2_pmp_csr_if bus ();

    el2_pmp_csr #(
        .PMP_ENTRIES     (16),
        .PMP_GRANULARITY (0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .pmp_pmpcfg  (pmp_pmpcfg),
        .pmp_pmpaddr (pmp_pmpaddr),
        .mseccfg     (mseccfg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request with rsp_ready=1; returns 1 time unit after accept.
    task automatic xact(input string tag, input logic we,
                        input logic [11:0] a, input logic [31:0] d);
        int n;
        @(negedge clk);
        bus.csr_req_valid = 1'b1;
        bus.csr_req_we    = we;
        bus.csr_req_addr  = a;
        bus.csr_req_wdata = d;
        bus.csr_rsp_ready = 1'b1;
        n = 0;
        while (!bus.csr_req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_rdy"}, 32'(bus.csr_req_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.csr_req_valid = 1'b0;
        chk({tag, "_vld"}, 32'(bus.csr_rsp_valid), 32'd1);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst = 1'b1;
        bus.csr_req_valid = 1'b1;
        bus.csr_req_we    = 1'b1;
        bus.csr_req_addr  = 12'h3A0;
        bus.csr_req_wdata = 32'hFF;
        bus.csr_rsp_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_rsp_valid", 32'(bus.csr_rsp_valid), 32'd0);
        chk("rst_rdata", bus.csr_rsp_rdata, 32'd0);
        chk("rst_err", 32'(bus.csr_rsp_err), 32'd0);
        chk("rst_cfg0", 32'(pmp_pmpcfg[0]), 32'd0);
        chk("rst_msec", 32'(mseccfg), 32'd0);
        @(negedge clk);
        bus.csr_req_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_ready", 32'(bus.csr_req_ready), 32'd1);
        chk("post_rst_vld", 32'(bus.csr_rsp_valid), 32'd0);
        chk("post_rst_cfg0", 32'(pmp_pmpcfg[0]), 32'd0);

        xact("wr_cfg0", 1'b1, 12'h3A0, 32'h0000_009F);
        chk("wr_cfg0_err", 32'(bus.csr_rsp_err), 32'd0);
        chk("wr_cfg0_old", bus.csr_rsp_rdata, 32'd0);
        chk("wr_cfg0_out", 32'(pmp_pmpcfg[0]), 32'h9F);
        xact("rd_cfg0", 1'b0, 12'h3A0, 32'd0);
        chk("rd_cfg0_data", bus.csr_rsp_rdata, 32'h0000_009F);

        xact("wr_addr1", 1'b1, 12'h3B1, 32'hABC);
        chk("wr_addr1_out", pmp_pmpaddr[1], 32'hABC);
        xact("wr_addr0_lk", 1'b1, 12'h3B0, 32'h1234);
        chk("addr0_lk_err", 32'(bus.csr_rsp_err), 32'd0);
        chk("addr0_lk_out", pmp_pmpaddr[0], 32'd0);

        xact("wr_cfg1", 1'b1, 12'h3A1, 32'h0000_8800);
        chk("cfg5_out", 32'(pmp_pmpcfg[5]), 32'h88);
        xact("wr_addr4_tor", 1'b1, 12'h3B4, 32'h100);
        chk("addr4_tor_out", pmp_pmpaddr[4], 32'd0);
        xact("wr_addr3", 1'b1, 12'h3B3, 32'h200);
        chk("addr3_out", pmp_pmpaddr[3], 32'h200);
        xact("wr_addr6", 1'b1, 12'h3B6, 32'h55);
        chk("addr6_out", pmp_pmpaddr[6], 32'h55);

        xact("wr_cfg2", 1'b1, 12'h3A2, 32'h007F_1B02);
        chk("cfg8_wonly", 32'(pmp_pmpcfg[8]), 32'h00);
        chk("cfg9_out", 32'(pmp_pmpcfg[9]), 32'h1B);
        chk("cfg10_b65", 32'(pmp_pmpcfg[10]), 32'h1F);
        xact("rd_cfg2", 1'b0, 12'h3A2, 32'd0);
        chk("rd_cfg2_data", bus.csr_rsp_rdata, 32'h001F_1B00);

        xact("msec_rlb", 1'b1, 12'h747, 32'h4);
        chk("msec_rlb_out", 32'(mseccfg), 32'd0);
        xact("msec_mml", 1'b1, 12'h747, 32'h1);
        chk("msec_mml_out", 32'(mseccfg), 32'd1);
        xact("rd_msec", 1'b0, 12'h747, 32'd0);
        chk("rd_msec_data", bus.csr_rsp_rdata, 32'd1);
        xact("msec_clr", 1'b1, 12'h747, 32'h0);
        chk("msec_clr_old", bus.csr_rsp_rdata, 32'd1);
        chk("msec_sticky", 32'(mseccfg), 32'd1);
        xact("msec_mmwp", 1'b1, 12'h747, 32'h2);
        chk("msec_mmwp_out", 32'(mseccfg), 32'd3);

        xact("wr_cfg3", 1'b1, 12'h3A3, 32'h0002_0384);
        chk("cfg12_mml_lx", 32'(pmp_pmpcfg[12]), 32'h00);
        chk("cfg13_out", 32'(pmp_pmpcfg[13]), 32'h03);
        chk("cfg14_mml_w", 32'(pmp_pmpcfg[14]), 32'h02);

        idle();
        @(negedge clk);
        bus.csr_req_valid = 1'b1;
        bus.csr_req_we    = 1'b0;
        bus.csr_req_addr  = 12'h3B3;
        bus.csr_rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("bp_vld", 32'(bus.csr_rsp_valid), 32'd1);
        chk("bp_data", bus.csr_rsp_rdata, 32'h200);
        bus.csr_req_addr = 12'h3B6;
        repeat (3) begin
            @(negedge clk);
            chk("bp_ready", 32'(bus.csr_req_ready), 32'd0);
            chk("bp_hold", bus.csr_rsp_rdata, 32'h200);
            chk("bp_hold_vld", 32'(bus.csr_rsp_valid), 32'd1);
        end
        @(negedge clk);
        bus.csr_rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("b2b_a6", bus.csr_rsp_rdata, 32'h55);
        bus.csr_req_addr = 12'h3B0;
        @(posedge clk);
        #1;
        chk("b2b_a0", bus.csr_rsp_rdata, 32'd0);
        chk("b2b_a0_vld", 32'(bus.csr_rsp_valid), 32'd1);
        bus.csr_req_addr = 12'h3B1;
        @(posedge clk);
        #1;
        chk("b2b_a1", bus.csr_rsp_rdata, 32'hABC);
        bus.csr_req_valid = 1'b0;

        xact("rd_unmap", 1'b0, 12'h3C5, 32'd0);
        chk("unmap_err", 32'(bus.csr_rsp_err), 32'd1);
        chk("unmap_data", bus.csr_rsp_rdata, 32'd0);
        xact("wr_unmap", 1'b1, 12'h3A4, 32'hFFFF_FFFF);
        chk("unmap_w_err", 32'(bus.csr_rsp_err), 32'd1);
        chk("unmap_w_cfg", 32'(pmp_pmpcfg[0]), 32'h9F);
        chk("unmap_w_cfg11", 32'(pmp_pmpcfg[11]), 32'h00);

        idle();
        @(negedge clk);
        bus.csr_req_valid = 1'b1;
        bus.csr_req_we    = 1'b0;
        bus.csr_req_addr  = 12'h3B3;
        bus.csr_rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.csr_req_valid = 1'b0;
        chk("pre_rst_vld", 32'(bus.csr_rsp_valid), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_vld", 32'(bus.csr_rsp_valid), 32'd0);
        chk("mid_rst_data", bus.csr_rsp_rdata, 32'd0);
        chk("mid_rst_cfg", 32'(|pmp_pmpcfg), 32'd0);
        chk("mid_rst_addr", 32'(|pmp_pmpaddr), 32'd0);
        chk("mid_rst_msec", 32'(mseccfg), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("no_replay", 32'(bus.csr_rsp_valid), 32'd0);
        chk("rel_ready", 32'(bus.csr_req_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
